// File: rtl/l1_dcache_pkg.sv
// Shared constants, types and helpers for the L1 data cache.
package cache_types;

  localparam int S_INDEX  = 3;                      // sets = 2**S_INDEX
  localparam int S_OFFSET = 5;                      // 32-byte line, fixed
  localparam int S_TAG    = 32 - S_OFFSET - S_INDEX;
  localparam int NUM_SETS = 1 << S_INDEX;

  typedef logic [255:0]       cache_line_t;
  typedef logic [S_TAG-1:0]   cache_tag_t;
  typedef logic [S_INDEX-1:0] cache_idx_t;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} dcache_state_t;

  // Merge one 32-bit store into a line, byte by byte under the mask.
  function automatic cache_line_t merge_word(cache_line_t line, logic [2:0] word,
                                             logic [3:0] be, logic [31:0] wdata);
    cache_line_t res;
    logic [7:0]  off;
    res = line;
    for (int b = 0; b < 4; b++) begin
      off = {word, b[1:0], 3'b000};
      if (be[b]) res[off +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/l1_dcache_if.sv
// CPU-side and memory-side buses of the L1 data cache.
interface l1_dcache_if;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_resp;
  logic [31:0] mem_rdata;

  modport master (output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
                  input  mem_resp, mem_rdata);
  modport slave  (input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
                  output mem_resp, mem_rdata);
endinterface

interface l1_dcache_pmem_if;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  modport master (output pmem_read, pmem_write, pmem_address, pmem_wdata,
                  input  pmem_rdata, pmem_resp);
  modport slave  (input  pmem_read, pmem_write, pmem_address, pmem_wdata,
                  output pmem_rdata, pmem_resp);
endinterface

// File: rtl/l1_dcache_control.sv
// Miss-handling FSM: IDLE serves hits, WRITEBACK flushes a dirty victim,
// FILL fetches the requested line. pmem strobes are registered.
module dcache_control
  import cache_types::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          hit,
  input  logic          dirty,
  input  logic          pmem_resp,
  output dcache_state_t state,
  output logic          pmem_read,
  output logic          pmem_write,
  output logic          latch_miss,
  output logic          wb_done,
  output logic          fill_done
);

  assign latch_miss = (state == IDLE) && req && !hit;
  assign wb_done    = (state == WRITEBACK) && pmem_resp;
  assign fill_done  = (state == FILL) && pmem_resp;

  // State transitions with registered pmem request strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req && !hit) begin
          if (dirty) begin
            state      <= WRITEBACK;
            pmem_write <= 1'b1;
          end else begin
            state      <= FILL;
            pmem_read  <= 1'b1;
          end
        end
        WRITEBACK: if (pmem_resp) begin
          state      <= FILL;
          pmem_write <= 1'b0;
          pmem_read  <= 1'b1;
        end
        FILL: if (pmem_resp) begin
          state      <= IDLE;
          pmem_read  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped write-back / write-allocate L1 data cache. Hits respond
// combinationally in the request cycle; misses go through dcache_control.
module l1_dcache
  import cache_types::*;
(
  input  logic             clk,
  input  logic             reset,
  l1_dcache_if.slave       cpu,
  l1_dcache_pmem_if.master pmem
);

  logic [NUM_SETS-1:0] valid;
  logic [NUM_SETS-1:0] dirty;
  cache_tag_t          tag_arr  [NUM_SETS];
  cache_line_t         data_arr [NUM_SETS];

  cache_tag_t    req_tag, miss_tag;
  cache_idx_t    req_idx, miss_idx;
  logic [2:0]    req_word;
  logic          req, hit, victim_dirty;
  cache_line_t   cur_line;
  dcache_state_t state;
  logic          latch_miss, wb_done, fill_done;
  logic [1:0]    unused_addr_bits;

  assign req_tag          = cpu.mem_address[31:S_OFFSET+S_INDEX];
  assign req_idx          = cpu.mem_address[S_OFFSET+S_INDEX-1:S_OFFSET];
  assign req_word         = cpu.mem_address[4:2];
  assign unused_addr_bits = cpu.mem_address[1:0];

  assign req          = cpu.mem_read | cpu.mem_write;
  assign hit          = req && valid[req_idx] && (tag_arr[req_idx] == req_tag);
  assign victim_dirty = valid[req_idx] && dirty[req_idx];
  assign cur_line     = data_arr[req_idx];

  dcache_control u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .hit        (hit),
    .dirty      (victim_dirty),
    .pmem_resp  (pmem.pmem_resp),
    .state      (state),
    .pmem_read  (pmem.pmem_read),
    .pmem_write (pmem.pmem_write),
    .latch_miss (latch_miss),
    .wb_done    (wb_done),
    .fill_done  (fill_done)
  );

  // Hits only complete while idle; read data is zeroed when not responding.
  assign cpu.mem_resp  = (state == IDLE) && hit;
  assign cpu.mem_rdata = cpu.mem_resp ? cur_line[{req_word, 5'b0} +: 32] : 32'h0;

  // pmem address/data come from the latched miss, never from live CPU inputs.
  always_comb begin
    pmem.pmem_address = 32'h0;
    pmem.pmem_wdata   = '0;
    case (state)
      WRITEBACK: begin
        pmem.pmem_address = {tag_arr[miss_idx], miss_idx, 5'b0};
        pmem.pmem_wdata   = data_arr[miss_idx];
      end
      FILL:    pmem.pmem_address = {miss_tag, miss_idx, 5'b0};
      default: ;
    endcase
  end

  // Capture the missing request so a dropped/changed request can't disturb it.
  always_ff @(posedge clk) begin
    if (reset) begin
      miss_tag <= '0;
      miss_idx <= '0;
    end else if (latch_miss) begin
      miss_tag <= req_tag;
      miss_idx <= req_idx;
    end
  end

  // Valid/dirty bookkeeping; these are the only cleared state on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_done) begin
      valid[miss_idx] <= 1'b1;
      dirty[miss_idx] <= 1'b0;
    end else if (wb_done) begin
      dirty[miss_idx] <= 1'b0;
    end else if (cpu.mem_resp && cpu.mem_write) begin
      dirty[req_idx]  <= 1'b1;
    end
  end

  // Line install on fill, byte-merged store on write hit.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_arr[miss_idx] <= pmem.pmem_rdata;
      tag_arr[miss_idx]  <= miss_tag;
    end else if (cpu.mem_resp && cpu.mem_write) begin
      data_arr[req_idx]  <= merge_word(cur_line, req_word, cpu.mem_byte_enable, cpu.mem_wdata);
    end
  end

endmodule

// File: tb/tb_l1_dcache.sv
// Directed bench: stimulus pushes expected responses, a monitor pops and
// compares on mem_resp; a simple memory model answers pmem requests.
module tb_l1_dcache;
  import cache_types::*;

  typedef struct { logic is_read; logic [31:0] rdata; } exp_t;
  typedef struct { logic we; logic [31:0] addr; logic [255:0] wdata; } ptx_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  l1_dcache_if      cpu ();
  l1_dcache_pmem_if pm ();

  l1_dcache dut (.clk(clk), .reset(reset), .cpu(cpu), .pmem(pm));

  exp_t  sb [$];
  ptx_t  plog [$];
  int    compared = 0, mismatched = 0, viol = 0, resp_cnt = 0;
  int    pmem_lat = 3;
  logic [255:0] mem [logic [31:0]];

  function automatic logic [255:0] dflt(logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'hA500_0000 | (a + 32'(i*4));
    return l;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Monitor: compare each response against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #3;
      if (!reset) begin
        if (pm.pmem_read && pm.pmem_write) viol++;
        if (cpu.mem_resp && (pm.pmem_read || pm.pmem_write)) viol++;
        if (cpu.mem_resp) begin
          resp_cnt++;
          if (sb.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL unexpected_resp: got resp at addr %h expected none", cpu.mem_address);
          end else begin
            e = sb.pop_front();
            if (e.is_read) chk("resp_rdata", cpu.mem_rdata, e.rdata);
            else           chk("resp_is_write", {31'b0, cpu.mem_write}, 32'd1);
          end
        end
      end
    end
  end

  // Memory model: answers a held pmem request after pmem_lat cycles.
  initial begin
    int   cnt;
    ptx_t p;
    cnt = 0;
    pm.pmem_resp  = 1'b0;
    pm.pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pm.pmem_resp = 1'b0;
      if (reset || !(pm.pmem_read || pm.pmem_write)) cnt = 0;
      else begin
        cnt++;
        if (cnt >= pmem_lat) begin
          cnt     = 0;
          p.we    = pm.pmem_write;
          p.addr  = pm.pmem_address;
          p.wdata = pm.pmem_wdata;
          plog.push_back(p);
          if (p.we) mem[p.addr] = p.wdata;
          else      pm.pmem_rdata = mem.exists(p.addr) ? mem[p.addr] : dflt(p.addr);
          pm.pmem_resp = 1'b1;
        end
      end
    end
  end

  task automatic access(input string n, input logic wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd,
                        input logic [31:0] exp_rd, output int cyc);
    exp_t e;
    e.is_read = !wr; e.rdata = exp_rd;
    sb.push_back(e);
    @(negedge clk);
    cpu.mem_read = !wr; cpu.mem_write = wr; cpu.mem_address = addr;
    cpu.mem_byte_enable = be; cpu.mem_wdata = wd;
    #1; cyc = 0;
    while (!cpu.mem_resp && cyc < 60) begin
      @(negedge clk); #1; cyc++;
    end
    if (!cpu.mem_resp) begin
      compared++; mismatched++;
      $display("FAIL %s_timeout: got no resp in %0d cycles expected resp", n, cyc);
    end
    @(posedge clk); #1;
    cpu.mem_read = 1'b0; cpu.mem_write = 1'b0;
  endtask

  task automatic check_log(input string n, input logic we, input logic [31:0] addr,
                           output logic [255:0] wdata);
    ptx_t p;
    wdata = '0;
    if (plog.size() == 0) begin
      compared++; mismatched++;
      $display("FAIL %s_missing: got no pmem transaction expected addr %h", n, addr);
    end else begin
      p = plog.pop_front();
      wdata = p.wdata;
      chk({n, "_we"}, {31'b0, p.we}, {31'b0, we});
      chk({n, "_addr"}, p.addr, addr);
    end
  endtask

  initial begin
    int cyc, rc;
    logic [255:0] wd, l;
    reset = 1'b1;
    cpu.mem_read = 0; cpu.mem_write = 0; cpu.mem_address = 0;
    cpu.mem_byte_enable = 0; cpu.mem_wdata = 0;
    l = dflt(32'h100); l[63:32] = 32'hDEADBEEF; mem[32'h100] = l;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #3;
    chk("rst_mem_resp",  {31'b0, cpu.mem_resp},   0);
    chk("rst_pmem_read", {31'b0, pm.pmem_read},   0);
    chk("rst_pmem_write",{31'b0, pm.pmem_write},  0);
    chk("rst_pmem_addr", pm.pmem_address,         0);
    chk("rst_pmem_wdata",{31'b0, |pm.pmem_wdata}, 0);
    chk("rst_mem_rdata", cpu.mem_rdata,           0);

    // 1: cold read miss
    access("t1", 0, 32'h104, 4'h0, 0, 32'hDEADBEEF, cyc);
    chk("t1_latency", cyc, 4);
    check_log("t1_fill", 0, 32'h100, wd);
    chk("t1_no_extra_pmem", plog.size(), 0);

    // 2: read hit
    access("t2", 0, 32'h104, 4'h0, 0, 32'hDEADBEEF, cyc);
    chk("t2_latency", cyc, 0);
    chk("t2_pmem_idle", plog.size(), 0);

    // 3: masked write hit, then read back
    access("t3w", 1, 32'h104, 4'b0011, 32'h12345678, 0, cyc);
    chk("t3w_latency", cyc, 0);
    access("t3r", 0, 32'h104, 4'h0, 0, 32'hDEAD5678, cyc);
    chk("t3r_latency", cyc, 0);

    // 4: dirty eviction (same index, tag 2)
    access("t4", 0, 32'h204, 4'h0, 0, 32'hA5000204, cyc);
    chk("t4_latency", cyc, 7);
    check_log("t4_wb", 1, 32'h100, wd);
    chk("t4_wb_word1", wd[63:32], 32'hDEAD5678);
    check_log("t4_fill", 0, 32'h200, wd);

    // 5: reset while in FILL
    @(negedge clk);
    pmem_lat = 20;
    cpu.mem_read = 1; cpu.mem_address = 32'h304;
    repeat (3) @(negedge clk);
    reset = 1'b1; cpu.mem_read = 0;
    @(negedge clk); #1;
    chk("t5_pmem_read", {31'b0, pm.pmem_read}, 0);
    chk("t5_mem_resp",  {31'b0, cpu.mem_resp}, 0);
    chk("t5_pmem_addr", pm.pmem_address,       0);
    reset = 1'b0;
    chk("t5_no_pmem", plog.size(), 0);
    pmem_lat = 3;
    access("t5r", 0, 32'h104, 4'h0, 0, 32'hDEAD5678, cyc);
    chk("t5r_latency", cyc, 4);
    check_log("t5_fill", 0, 32'h100, wd);

    // 6: request dropped during FILL
    rc = resp_cnt;
    @(negedge clk);
    cpu.mem_read = 1; cpu.mem_address = 32'h404;
    @(negedge clk);
    cpu.mem_read = 0;
    repeat (6) @(negedge clk);
    chk("t6_no_resp", resp_cnt, rc);
    check_log("t6_fill", 0, 32'h400, wd);
    access("t6r", 0, 32'h404, 4'h0, 0, 32'hA5000404, cyc);
    chk("t6r_latency", cyc, 0);
    chk("t6_pmem_idle", plog.size(), 0);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("protocol_viol", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/l1_dcache.md
Name: l1_dcache

Overview:
Direct-mapped, write-back, write-allocate L1 data cache that sits directly downstream of the CPU data port (the read_b/write_b/wmask_b/address_b/wdata_b/resp_b/rdata_b group) and upstream of physical memory. It serves hits with zero added wait cycles, so the CPU's mem_access_stall deasserts in the request cycle. Misses go through a writeback/fill FSM on a 256-bit line interface.

Parameters:
S_INDEX, 3, index bits; sets = 2**S_INDEX (default 8).
S_OFFSET, 5, line offset bits; line = 32 bytes. Fixed and documented, not meant to be overridden.
S_TAG, 32-S_OFFSET-S_INDEX, tag width (derived).

Ports:
clk  in  1  Clock. Single clock domain, rising edge.
reset  in  1  Synchronous, active-high reset.
mem_read  in  1  CPU read request; held until mem_resp.
mem_write  in  1  CPU write request; held until mem_resp.
mem_byte_enable  in  4  Byte write mask for mem_wdata.
mem_address  in  32  Byte address. [1:0] ignored; word = [4:2]; index = [S_OFFSET+S_INDEX-1:S_OFFSET]; tag = [31:S_OFFSET+S_INDEX].
mem_wdata  in  32  Store data.
mem_resp  out  1  Request complete this cycle.
mem_rdata  out  32  Selected word; valid when mem_resp && mem_read.
pmem_read  out  1  Line fill request; held until pmem_resp.
pmem_write  out  1  Line writeback request; held until pmem_resp.
pmem_address  out  32  Line-aligned address ([4:0]=0).
pmem_wdata  out  256  Victim line.
pmem_rdata  in  256  Fill line; valid with pmem_resp.
pmem_resp  in  1  Memory completion, 1 cycle.

Behaviour:
- Storage
  - Per set: valid, dirty, tag and 256-bit data, all in flops.
  - Lookup is combinational.
- FSM states: IDLE, WRITEBACK, FILL.
- IDLE
  - hit = (mem_read|mem_write) && valid[idx] && tag[idx]==req_tag.
  - On hit: mem_resp=1 in the same cycle.
  - Read hit: mem_rdata = line word [addr[4:2]].
  - Write hit: on that clock edge, merge mem_wdata into word [addr[4:2]] per mem_byte_enable and set dirty=1.
  - Miss with dirty victim: go to WRITEBACK. Otherwise go to FILL. mem_resp=0.
  - No request: stay in IDLE, all outputs inactive.
- WRITEBACK
  - pmem_write=1, pmem_address={victim_tag, idx, 5'b0}, pmem_wdata=victim line.
  - On pmem_resp: clear dirty, go to FILL.
- FILL
  - pmem_read=1, pmem_address={req_tag, idx, 5'b0}.
  - On pmem_resp: install line, tag=req_tag, valid=1, dirty=0, go to IDLE.
  - The next cycle is then a hit and responds. Miss latency = writeback + fill memory latency + 1 cycle.
- mem_resp is never asserted in WRITEBACK or FILL.
- pmem_read and pmem_write are never both high.
- mem_read && mem_write together: treated as a write.
- Request dropped or changed mid-miss: the in-flight pmem transaction completes and the line is installed. The FSM then returns to IDLE and re-evaluates the current inputs.
- pmem_address and pmem_wdata are held stable for the whole transaction; they are derived from registered state, not from live CPU inputs.
- mem_rdata is 0 when mem_resp=0.
- Reset (any state, including mid-miss)
  - Next cycle: state=IDLE; all valid and dirty cleared; data and tag contents don't-care.
  - Outputs mem_resp=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, mem_rdata=0.
  - A pmem_resp arriving after reset is ignored.

Decomposition:
- Package cache_types holds:
  - constants S_INDEX, S_OFFSET, S_TAG;
  - typedefs cache_line_t (logic [255:0]) and cache_tag_t;
  - enum dcache_state_t {IDLE, WRITEBACK, FILL}.
- Sub-module dcache_control: the FSM. Inputs hit, dirty, pmem_resp; outputs the state and load/select strobes.
- Arrays and muxing stay in l1_dcache.

Test Plan:
1. Cold read miss: reset, read 0x00000104; pmem_resp after 3 cycles with word1=0xDEADBEEF.
   -> pmem_read high, pmem_address=0x00000100, no pmem_write; mem_resp one cycle after pmem_resp with mem_rdata=0xDEADBEEF.
2. Read hit: after test 1, read 0x00000104.
   -> mem_resp and mem_rdata=0xDEADBEEF in the same cycle, pmem idle.
3. Write hit masked: write 0x00000104, mask 4'b0011, data 0x12345678.
   -> mem_resp same cycle; a subsequent read returns 0xDEAD5678.
4. Dirty eviction: after test 3, read 0x00000204 (same index 0, tag 2).
   -> pmem_write, address 0x00000100, pmem_wdata word1=0xDEAD5678; then pmem_read at 0x00000200; then mem_resp.
5. Reset mid-fill: assert reset in FILL before pmem_resp.
   -> next cycle pmem_read=0 and mem_resp=0; re-read 0x00000104 misses (valid cleared).
6. Request dropped mid-fill: deassert mem_read in FILL, then pmem_resp.
   -> line installed, no mem_resp; a later read of the same address hits with 0 wait.
